vote_ballot_capture: RTL and testbench

Front-end ballot stage for the voting machine: conditions the raw candidate-select and cast push-buttons (synchronise and debounce), validates that exactly one candidate is selected when cast is pressed, and hands one vote record per voter to the downstream tally core over a valid/ready handshake. A post-vote lockout prevents one button press from being counted twice. Sits between the pad-level `ui_in` bits and the tally logic inside `tt_um_voting_machine`.

---
 rtl/voting_pkg.sv | 20 ++
 rtl/vote_debounce.sv | 40 ++++
 rtl/vote_ballot_capture.sv | 140 ++++++++++++++
 tb/tb_vote_ballot_capture.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voting_pkg.sv
// Shared types and helpers for the voting-machine ballot front end.
package voting_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    // Width of a candidate index that can also carry the abstain code.
    function automatic int unsigned cand_width(input int unsigned num_cand);
        return $clog2(num_cand + 1);
    endfunction

    // Abstentions are reported one past the highest real candidate index.
    function automatic int unsigned abstain_code(input int unsigned num_cand);
        return num_cand;
    endfunction

endpackage

// File: rtl/vote_debounce.sv
// One-bit 2-flop synchroniser followed by a stable-count debouncer.
module vote_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] stable_cnt;

    // The count tracks consecutive cycles the synchronised input disagrees with level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level      <= sync2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/vote_ballot_capture.sv
// Ballot capture: debounced buttons, one-hot validation, vote handshake and lockout.
// Optional feature macro: BALLOT_ABSTAIN_EN (zero selections cast as an abstention).
module vote_ballot_capture
    import voting_pkg::*;
#(
    parameter  int unsigned NUM_CAND        = 4,
    parameter  int unsigned DEBOUNCE_CYCLES = 16,
    parameter  int unsigned LOCKOUT_CYCLES  = 64,
    localparam int unsigned CW              = cand_width(NUM_CAND)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CAND-1:0] cand_btn,
    input  logic                cast_btn,
    input  logic                session_open,
    output logic                vote_valid,
    output logic [CW-1:0]       vote_cand,
    input  logic                vote_ready,
    output logic                invalid_pulse,
    output logic                busy,
    output logic [7:0]          ballot_cnt
);

    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

    logic [NUM_CAND:0]   raw_all;
    logic [NUM_CAND:0]   db_all;
    logic [NUM_CAND-1:0] cand_db;
    logic                cast_db;
    logic                cast_prev;
    logic                cast_event;
    logic [CW-1:0]       sel_cnt;
    logic [CW-1:0]       sel_idx;
    logic                one_hot;
    logic                none_sel;
    logic                inputs_clear;
    logic [LW-1:0]       lock_cnt;
    logic                lock_done;
    state_t              state;

    assign raw_all = {cast_btn, cand_btn};

    for (genvar i = 0; i <= NUM_CAND; i++) begin : g_db
        vote_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_all[i]),
            .level(db_all[i])
        );
    end

    assign cand_db      = db_all[NUM_CAND-1:0];
    assign cast_db      = db_all[NUM_CAND];
    assign cast_event   = cast_db & ~cast_prev;
    assign inputs_clear = ~|db_all;
    assign lock_done    = (lock_cnt == LW'(LOCKOUT_CYCLES - 1));

    // Population count and index of the selected candidate.
    always_comb begin
        sel_cnt = '0;
        sel_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cand_db[i]) begin
                sel_cnt = sel_cnt + CW'(1);
                sel_idx = CW'(i);
            end
        end
    end

    assign one_hot  = (sel_cnt == CW'(1));
    assign none_sel = (sel_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            vote_valid    <= 1'b0;
            vote_cand     <= '0;
            invalid_pulse <= 1'b0;
            busy          <= 1'b0;
            ballot_cnt    <= 8'd0;
            lock_cnt      <= '0;
            cast_prev     <= 1'b0;
        end else begin
            cast_prev     <= cast_db;
            invalid_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cast_event && session_open) begin
                        if (one_hot) begin
                            state      <= ST_EMIT;
                            vote_valid <= 1'b1;
                            busy       <= 1'b1;
                            vote_cand  <= sel_idx;
                        end
`ifdef BALLOT_ABSTAIN_EN
                        else if (none_sel) begin
                            state      <= ST_EMIT;
                            vote_valid <= 1'b1;
                            busy       <= 1'b1;
                            vote_cand  <= CW'(abstain_code(NUM_CAND));
                        end
`endif
                        else begin
                            invalid_pulse <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (vote_ready) begin
                        state      <= ST_LOCKOUT;
                        vote_valid <= 1'b0;
                        ballot_cnt <= ballot_cnt + 8'd1;
                        lock_cnt   <= '0;
                    end
                end
                ST_LOCKOUT: begin
                    // Leave only once the window has elapsed and every button is released.
                    if (!lock_done) begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end else if (inputs_clear) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    vote_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Only consumed when abstention is enabled.
    logic unused_none;
    assign unused_none = none_sel;

endmodule

// File: tb/tb_vote_ballot_capture.sv
// Self-checking bench for vote_ballot_capture: directed table, corner sequences, random vs model.
module tb_vote_ballot_capture;

    localparam int unsigned NC = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned LK = 8;
    localparam int unsigned CW = 3;
`ifdef BALLOT_ABSTAIN_EN
    localparam bit ABST = 1'b1;
`else
    localparam bit ABST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] cand_btn;
    logic          cast_btn;
    logic          session_open;
    logic          vote_valid;
    logic [CW-1:0] vote_cand;
    logic          vote_ready;
    logic          invalid_pulse;
    logic          busy;
    logic [7:0]    ballot_cnt;

    always #5 clk = ~clk;

    vote_ballot_capture #(
        .NUM_CAND       (NC),
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cand_btn     (cand_btn),
        .cast_btn     (cast_btn),
        .session_open (session_open),
        .vote_valid   (vote_valid),
        .vote_cand    (vote_cand),
        .vote_ready   (vote_ready),
        .invalid_pulse(invalid_pulse),
        .busy         (busy),
        .ballot_cnt   (ballot_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: raw history window, debounced levels, pending vote and lockout age.
    logic [NC:0]   hist [DB+2];
    logic [NC:0]   m_db;
    logic          m_prev_cast;
    bit            m_pending;
    bit            m_lock;
    int            m_lock_age;
    logic [CW-1:0] m_cand;
    bit            m_inv;
    logic [7:0]    m_cnt;

    int            xfer_seen = 0;
    int            inv_seen  = 0;
    logic [CW-1:0] last_cand = '0;

    typedef struct {
        logic          sess;
        logic [NC-1:0] cand;
        int            hold;
        int            exp_xfer;
        int            exp_inv;
        int            exp_cand;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [NC:0] nxt;
        bit          ev;
        bit          flip;
        int          ones;
        int          idx;
        if (rst) begin
            for (int i = 0; i < DB + 2; i++) hist[i] = '0;
            m_db = '0; m_prev_cast = 1'b0; m_pending = 0; m_lock = 0;
            m_lock_age = 0; m_cand = '0; m_inv = 0; m_cnt = 8'd0;
            return;
        end
        ev    = m_db[NC] && !m_prev_cast;
        m_inv = 0;
        if (m_pending) begin
            if (vote_ready) begin
                m_pending  = 0;
                m_cnt      = m_cnt + 8'd1;
                m_lock     = 1;
                m_lock_age = 0;
            end
        end else if (m_lock) begin
            m_lock_age++;
            if (m_lock_age >= int'(LK) && m_db == '0) m_lock = 0;
        end else if (ev && session_open) begin
            ones = 0;
            idx  = 0;
            for (int b = 0; b < int'(NC); b++) begin
                if (m_db[b]) begin ones++; idx = b; end
            end
            if (ones == 1) begin
                m_pending = 1; m_cand = CW'(idx);
            end else if (ones == 0 && ABST) begin
                m_pending = 1; m_cand = CW'(NC);
            end else begin
                m_inv = 1;
            end
        end
        for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {cast_btn, cand_btn};
        // A level flips once the synchronised input has disagreed for DB cycles running.
        for (int b = 0; b <= int'(NC); b++) begin
            flip = 1;
            for (int j = 2; j <= int'(DB) + 1; j++) if (hist[j][b] == m_db[b]) flip = 0;
            nxt[b] = flip ? ~m_db[b] : m_db[b];
        end
        m_prev_cast = m_db[NC];
        m_db        = nxt;
    endtask

    task automatic tick();
        model_step();
        if (vote_valid && vote_ready && !rst) begin
            xfer_seen++;
            last_cand = vote_cand;
        end
        @(posedge clk);
        @(negedge clk);
        inv_seen += int'(invalid_pulse);
        check("vote_valid", int'(vote_valid), int'(m_pending));
        check("vote_cand", int'(vote_cand), int'(m_cand));
        check("invalid_pulse", int'(invalid_pulse), int'(m_inv));
        check("busy", int'(busy), int'(m_pending || m_lock));
        check("ballot_cnt", int'(ballot_cnt), int'(m_cnt));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Wait for vote_valid with a cycle budget; an expired budget counts as a failure.
    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !vote_valid; i++) tick();
        check(name, int'(vote_valid), 1);
    endtask

    initial begin
        int x0;
        int i0;
        for (int i = 0; i < DB + 2; i++) hist[i] = '0;
        m_db = '0; m_prev_cast = 1'b0; m_pending = 0; m_lock = 0;
        m_lock_age = 0; m_cand = '0; m_inv = 0; m_cnt = 8'd0;

        vecs[0] = '{1'b1, 4'b0100, 10, 1, 0, 2};
        vecs[1] = '{1'b1, 4'b1001, 10, 0, 1, 0};
        vecs[2] = '{1'b1, 4'b0000, 10, ABST ? 1 : 0, ABST ? 0 : 1, 4};
        vecs[3] = '{1'b0, 4'b0010, 10, 0, 0, 0};
        vecs[4] = '{1'b1, 4'b0001, 10, 1, 0, 0};
        vecs[5] = '{1'b1, 4'b1000, 10, 1, 0, 3};
        vecs[6] = '{1'b1, 4'b0010, 2, 0, 0, 0};
        vecs[7] = '{1'b1, 4'b1111, 10, 0, 1, 0};

        // Reset with buttons pressed.
        rst = 1'b1; cand_btn = 4'hF; cast_btn = 1'b1; session_open = 1'b1; vote_ready = 1'b1;
        @(negedge clk);
        ticks(2);
        check("rst_valid", int'(vote_valid), 0);
        check("rst_cand", int'(vote_cand), 0);
        check("rst_inv", int'(invalid_pulse), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt", int'(ballot_cnt), 0);
        rst = 1'b0; cand_btn = '0; cast_btn = 1'b0;
        ticks(10);

        // Directed vector table.
        for (int v = 0; v < 8; v++) begin
            session_open = vecs[v].sess; vote_ready = 1'b1; cand_btn = vecs[v].cand;
            ticks(8);
            x0 = xfer_seen; i0 = inv_seen;
            cast_btn = 1'b1; ticks(vecs[v].hold);
            cast_btn = 1'b0; ticks(10);
            cand_btn = '0; ticks(30);
            check($sformatf("vec%0d_xfer", v), xfer_seen - x0, vecs[v].exp_xfer);
            check($sformatf("vec%0d_inv", v), inv_seen - i0, vecs[v].exp_inv);
            if (vecs[v].exp_xfer > 0) check($sformatf("vec%0d_cand", v), int'(last_cand), vecs[v].exp_cand);
            session_open = 1'b1;
        end

        // Backpressure: record held stable until ready.
        vote_ready = 1'b0; cand_btn = 4'b0010; ticks(8);
        x0 = xfer_seen;
        cast_btn = 1'b1;
        wait_valid("bp_valid_seen");
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_cand_stable", int'(vote_cand), 1);
            check("bp_valid_held", int'(vote_valid), 1);
        end
        vote_ready = 1'b1; cast_btn = 1'b0; ticks(4);
        cand_btn = '0; ticks(30);
        check("bp_one_xfer", xfer_seen - x0, 1);

        // Bouncing cast: short glitches never form a vote.
        cand_btn = 4'b0001; ticks(8);
        x0 = xfer_seen; i0 = inv_seen;
        for (int k = 0; k < 8; k++) begin
            cast_btn = 1'b1; ticks($urandom_range(1, 3));
            cast_btn = 1'b0; ticks($urandom_range(1, 3));
        end
        ticks(20);
        check("bounce_no_xfer", xfer_seen - x0, 0);
        check("bounce_no_inv", inv_seen - i0, 0);
        for (int k = 0; k < 4; k++) begin
            cast_btn = 1'b1; ticks($urandom_range(1, 3));
            cast_btn = 1'b0; ticks(1);
        end
        cast_btn = 1'b1; ticks(12);
        cast_btn = 1'b0; ticks(10);
        cand_btn = '0; ticks(30);
        check("bounce_then_hold", xfer_seen - x0, 1);

        // Cast held across the lockout window, then released and pressed again.
        cand_btn = 4'b0100; ticks(8);
        x0 = xfer_seen;
        cast_btn = 1'b1; ticks(60);
        check("lock_busy_held", int'(busy), 1);
        check("lock_one_xfer", xfer_seen - x0, 1);
        cast_btn = 1'b0; cand_btn = '0; ticks(20);
        check("lock_released_idle", int'(busy), 0);
        cand_btn = 4'b0100; ticks(8);
        cast_btn = 1'b1; ticks(10);
        cast_btn = 1'b0; cand_btn = '0; ticks(30);
        check("lock_repress_xfer", xfer_seen - x0, 2);

        // Session closing during EMIT still delivers the vote.
        vote_ready = 1'b0; cand_btn = 4'b1000; ticks(8);
        x0 = xfer_seen;
        cast_btn = 1'b1;
        wait_valid("sess_valid_seen");
        session_open = 1'b0; ticks(3);
        vote_ready = 1'b1; ticks(3);
        check("sess_close_xfer", xfer_seen - x0, 1);
        check("sess_close_cand", int'(last_cand), 3);
        cast_btn = 1'b0; cand_btn = '0; ticks(30);
        session_open = 1'b1;

        // Reset during EMIT drops the vote.
        vote_ready = 1'b0; cand_btn = 4'b0010; ticks(8);
        cast_btn = 1'b1;
        wait_valid("rst_emit_valid_seen");
        cast_btn = 1'b0; cand_btn = '0; rst = 1'b1;
        tick();
        check("rst_emit_valid", int'(vote_valid), 0);
        check("rst_emit_cnt", int'(ballot_cnt), 0);
        rst = 1'b0; vote_ready = 1'b1;
        x0 = xfer_seen;
        ticks(30);
        check("rst_emit_no_xfer", xfer_seen - x0, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < int'(NC); b++) if ($urandom_range(0, 19) == 0) cand_btn[b] = ~cand_btn[b];
            if ($urandom_range(0, 14) == 0) cast_btn = ~cast_btn;
            if ($urandom_range(0, 49) == 0) session_open = ~session_open;
            vote_ready = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
